// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM: state codes, datapath
// mux selects, instruction-class codes and the raw control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    LINK   = 4'd10
  } state_t;

  // Plain-vector views of the states so the register can hold codes 11-15
  localparam logic [3:0] S_FETCH  = FETCH;
  localparam logic [3:0] S_DECODE = DECODE;
  localparam logic [3:0] S_MEMADR = MEMADR;
  localparam logic [3:0] S_MEMRD  = MEMRD;
  localparam logic [3:0] S_MEMWB  = MEMWB;
  localparam logic [3:0] S_MEMWR  = MEMWR;
  localparam logic [3:0] S_EXECR  = EXECR;
  localparam logic [3:0] S_EXECI  = EXECI;
  localparam logic [3:0] S_ALUWB  = ALUWB;
  localparam logic [3:0] S_BRANCH = BRANCH;
  localparam logic [3:0] S_LINK   = LINK;

  localparam logic       ADR_PC         = 1'b0;
  localparam logic       ADR_ALUOUT     = 1'b1;
  localparam logic [1:0] SRCA_RN        = 2'b00;
  localparam logic [1:0] SRCA_PC        = 2'b01;
  localparam logic [1:0] SRCB_RM        = 2'b00;
  localparam logic [1:0] SRCB_IMM       = 2'b01;
  localparam logic [1:0] SRCB_FOUR      = 2'b10;
  localparam logic [1:0] RES_ALUOUT     = 2'b00;
  localparam logic [1:0] RES_DATA       = 2'b01;
  localparam logic [1:0] RES_ALURESULT  = 2'b10;
  localparam logic [1:0] RES_PC         = 2'b11;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Unqualified per-state controls; write enables are refined by the top level
  typedef struct packed {
    logic       memReq;
    logic       adrSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       aluOp;
    logic       linkSel;
    logic       regW;
    logic       memW;
    logic       pcWBranch;
    logic       pcWWb;
    logic       isFetch;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_out.sv
// Combinational state-to-control decode. Pure Moore view: no input
// qualification happens here.
module mc_ctrl_out
  import mc_pkg::*;
(
  input  logic [3:0] i_state,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memReq    = 1'b1;
        o_ctrl.adrSrc    = ADR_PC;
        o_ctrl.aluSrcA   = SRCA_PC;
        o_ctrl.aluSrcB   = SRCB_FOUR;
        o_ctrl.resultSrc = RES_ALURESULT;
        o_ctrl.isFetch   = 1'b1;
      end
      S_DECODE: begin
        o_ctrl.aluSrcA   = SRCA_PC;
        o_ctrl.aluSrcB   = SRCB_FOUR;
        o_ctrl.resultSrc = RES_ALURESULT;
      end
      S_MEMADR: begin
        o_ctrl.aluSrcA   = SRCA_RN;
        o_ctrl.aluSrcB   = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.memReq    = 1'b1;
        o_ctrl.adrSrc    = ADR_ALUOUT;
      end
      S_MEMWR: begin
        o_ctrl.memReq    = 1'b1;
        o_ctrl.adrSrc    = ADR_ALUOUT;
        o_ctrl.memW      = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.resultSrc = RES_DATA;
        o_ctrl.regW      = 1'b1;
        o_ctrl.pcWWb     = 1'b1;
      end
      S_EXECR: begin
        o_ctrl.aluSrcB   = SRCB_RM;
        o_ctrl.aluOp     = 1'b1;
      end
      S_EXECI: begin
        o_ctrl.aluSrcB   = SRCB_IMM;
        o_ctrl.aluOp     = 1'b1;
      end
      S_ALUWB: begin
        o_ctrl.resultSrc = RES_ALUOUT;
        o_ctrl.regW      = 1'b1;
        o_ctrl.pcWWb     = 1'b1;
      end
      S_LINK: begin
        o_ctrl.resultSrc = RES_PC;
        o_ctrl.linkSel   = 1'b1;
        o_ctrl.regW      = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.aluSrcB   = SRCB_IMM;
        o_ctrl.resultSrc = RES_ALURESULT;
        o_ctrl.pcWBranch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: state register, next-state logic, condition and
// destination qualification of write enables, and reset output gating.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       linkSelect,
  output logic       RegW,
  output logic       MemW,
  output logic       PCWrite,
  output logic       illegal,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic       r_running;
  logic [3:0] w_next;
  ctrl_t      w_ctrl;
  logic       w_run;
  logic       w_cmpClass;
  logic       w_regW;
  logic       w_pcW;
  logic       w_unused;

  // r_running delays the first request until the edge that sees reset high
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_running <= 1'b0;
    end else begin
      r_state   <= r_running ? w_next : S_FETCH;
      r_running <= 1'b1;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   w_next = Funct[4] ? S_LINK : S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      S_LINK:   w_next = S_BRANCH;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_ctrl_out u_ctrlOut (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Compare/test ops set flags only, so their ALUWB must not write Rd
  assign w_cmpClass = (r_state == S_ALUWB) && (Funct[4:3] == 2'b10);
  assign w_regW     = w_ctrl.regW & CondEx & ~w_cmpClass;
  assign w_pcW      = (w_ctrl.isFetch & mem_ready)
                    | (w_ctrl.pcWBranch & CondEx)
                    | (w_ctrl.pcWWb & w_regW & (Rd == 4'd15));
  assign w_run      = reset & r_running;
  assign w_unused   = ^Funct[2:1];

  assign mem_req    = w_run & w_ctrl.memReq;
  assign IRWrite    = w_run & w_ctrl.isFetch & mem_ready;
  assign AdrSrc     = w_run & w_ctrl.adrSrc;
  assign ALUSrcA    = w_run ? w_ctrl.aluSrcA   : 2'b00;
  assign ALUSrcB    = w_run ? w_ctrl.aluSrcB   : 2'b00;
  assign ResultSrc  = w_run ? w_ctrl.resultSrc : 2'b00;
  assign ALUOp      = w_run & w_ctrl.aluOp;
  assign linkSelect = w_run & w_ctrl.linkSel;
  assign RegW       = w_run & w_regW;
  assign MemW       = w_run & w_ctrl.memW & CondEx;
  assign PCWrite    = w_run & w_pcW;
  assign illegal    = w_run & (r_state == S_DECODE) & (Op == OP_UNDEF);
  assign state      = w_run ? r_state : 4'd0;

endmodule
